// File: rtl/udp_checksum_check.sv
// Receive-side UDP checksum verifier; forwards the stream and flags bad or runt datagrams on tuser.
// Latency: 1 cycle, input beat to output beat, full throughput including back-to-back datagrams.
// Backpressure: axis_i_tready = !axis_o_tvalid || axis_o_tready; the output holds while stalled.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   axis_i_*              16-bit big-endian stream: pseudo-header + UDP header + payload
//   axis_o_*              registered copy of the input stream
//   axis_o_tuser          on the tlast beat: bit0 = checksum bad, bit1 = runt; 0 on other beats
//   stat_ok_count         wrapping count of datagrams that passed
//   stat_bad_count        wrapping count of datagrams that were flagged
module udp_checksum_check #(
    parameter int CSUM_WORD_IDX = 9,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   axis_i_tready,
    input  logic                   axis_i_tvalid,
    input  logic                   axis_i_tlast,
    input  logic [1:0]             axis_i_tkeep,
    input  logic [15:0]            axis_i_tdata,
    input  logic                   axis_o_tready,
    output logic                   axis_o_tvalid,
    output logic                   axis_o_tlast,
    output logic [1:0]             axis_o_tkeep,
    output logic [15:0]            axis_o_tdata,
    output logic [1:0]             axis_o_tuser,
    output logic [COUNT_WIDTH-1:0] stat_ok_count,
    output logic [COUNT_WIDTH-1:0] stat_bad_count
);

    // Index only needs to reach CSUM_WORD_IDX+1 (saturating).
    localparam int IDX_W = $clog2(CSUM_WORD_IDX + 2);
    localparam logic [IDX_W-1:0] IDX_CSUM = IDX_W'(CSUM_WORD_IDX);
    localparam logic [IDX_W-1:0] IDX_SAT  = IDX_W'(CSUM_WORD_IDX + 1);

    typedef enum logic {
        SM_FIRST = 1'b0,
        SM_SUM   = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [16:0]      r_acc;
    logic [IDX_W-1:0] r_idx;
    logic             r_csum_zero;

    logic             w_accept;
    logic [15:0]      w_sum_word;
    logic [16:0]      w_acc_base;
    logic [16:0]      w_acc_next;
    logic [IDX_W-1:0] w_idx_cur;
    logic             w_csum_zero;
    logic [16:0]      w_fold1;
    logic [15:0]      w_fold2;
    logic             w_runt;
    logic             w_bad;
    logic [1:0]       w_user;

    assign axis_i_tready = !axis_o_tvalid || axis_o_tready;
    assign w_accept      = axis_i_tvalid && axis_i_tready;

    // Only an exact 2'b10 on the last beat means "odd byte"; illegal keeps count as full words.
    assign w_sum_word = (axis_i_tlast && axis_i_tkeep == 2'b10) ?
                        {axis_i_tdata[15:8], 8'h00} : axis_i_tdata;

    // A new datagram starts from a zero accumulator and index, whatever the registers hold.
    assign w_acc_base = (r_state == SM_FIRST) ? 17'd0 : r_acc;
    assign w_idx_cur  = (r_state == SM_FIRST) ? '0 : r_idx;

    // End-around carry deferred by one word: the stored bit 16 is added into the next sum.
    assign w_acc_next = {1'b0, w_acc_base[15:0]} + {16'd0, w_acc_base[16]} + {1'b0, w_sum_word};

    // The checksum word may itself be the last beat, so use the live compare in that case.
    assign w_csum_zero = (w_idx_cur == IDX_CSUM) ? (axis_i_tdata == 16'h0000) : r_csum_zero;

    // Two folds: the first can yield 0x10000, the second cannot carry again.
    assign w_fold1 = {1'b0, w_acc_next[15:0]} + {16'd0, w_acc_next[16]};
    assign w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};

    assign w_runt = (w_idx_cur < IDX_CSUM);
    assign w_bad  = !w_csum_zero && (w_fold2 != 16'hFFFF);
    assign w_user = w_runt ? 2'b10 : {1'b0, w_bad};

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = axis_i_tlast ? SM_FIRST : SM_SUM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SM_FIRST;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= 17'd0;
            r_idx       <= '0;
            r_csum_zero <= 1'b0;
        end else if (w_accept) begin
            r_acc       <= w_acc_next;
            r_csum_zero <= w_csum_zero;
            if (axis_i_tlast) begin
                r_idx <= '0;
            end else if (w_idx_cur < IDX_SAT) begin
                r_idx <= w_idx_cur + 1'b1;
            end else begin
                r_idx <= w_idx_cur;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            axis_o_tvalid <= 1'b0;
            axis_o_tlast  <= 1'b0;
            axis_o_tkeep  <= 2'b00;
            axis_o_tdata  <= 16'h0000;
            axis_o_tuser  <= 2'b00;
        end else if (w_accept) begin
            axis_o_tvalid <= 1'b1;
            axis_o_tlast  <= axis_i_tlast;
            axis_o_tkeep  <= axis_i_tkeep;
            axis_o_tdata  <= axis_i_tdata;
            axis_o_tuser  <= axis_i_tlast ? w_user : 2'b00;
        end else if (axis_o_tready) begin
            axis_o_tvalid <= 1'b0;
        end
    end

    // Counted at input acceptance so the verdict matches the tuser registered with the beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ok_count  <= '0;
            stat_bad_count <= '0;
        end else if (w_accept && axis_i_tlast) begin
            if (w_user == 2'b00) begin
                stat_ok_count <= stat_ok_count + 1'b1;
            end else begin
                stat_bad_count <= stat_bad_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/udp_checksum_check.md
Name: udp_checksum_check

Overview:
- Receive-side UDP checksum verifier: the checking counterpart to the transmit-path checksum generator.
- Accepts a 16-bit big-endian AXI-Stream of pseudo-header + UDP header + payload.
- Forwards it unchanged through a one-stage register pipeline, and flags checksum or runt errors on tuser of the last output beat.
- Sits between the IPv4 RX parser and the UDP port demux; it also keeps wrapping good/bad packet counters.

Parameters:
- CSUM_WORD_IDX, 9, zero-based word index of the UDP checksum field within the stream (6 pseudo-header words + 3 header words).
- COUNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- axis_i_tready  out  1  input ready.
- axis_i_tvalid  in  1  input valid.
- axis_i_tlast  in  1  last word of datagram.
- axis_i_tkeep  in  2  byte enables, bit1 = tdata[15:8]; meaningful on the last beat only.
- axis_i_tdata  in  16  data, first byte in [15:8].
- axis_o_tready  in  1  output ready.
- axis_o_tvalid  out  1  output valid.
- axis_o_tlast  out  1  registered copy of tlast.
- axis_o_tkeep  out  2  registered copy of tkeep.
- axis_o_tdata  out  16  registered copy of tdata.
- axis_o_tuser  out  2  bit0 = checksum bad, bit1 = runt; valid only with tlast, 0 otherwise.
- stat_ok_count  out  COUNT_WIDTH  datagrams passed.
- stat_bad_count  out  COUNT_WIDTH  datagrams flagged.

Behaviour:
- Reset (async assert): axis_o_tvalid=0, axis_o_tlast=0, axis_o_tuser=0, axis_o_tdata=0, axis_o_tkeep=0.
  - Also clears: accumulator, word index, csum_zero flag, both counters.
  - On deassert the next accepted beat is word 0 of a new datagram.
- Handshake:
  - axis_i_tready = !axis_o_tvalid || axis_o_tready.
  - A beat is accepted on tvalid&&tready and appears on the output the next cycle. Latency is 1 cycle.
  - Output holds data stable while axis_o_tvalid && !axis_o_tready.
  - Full throughput with no bubbles, including back-to-back datagrams: the word after tlast is word 0.
- States:
  - SM_FIRST: word 0 expected.
  - SM_SUM: mid-datagram.
  - Transitions: SM_FIRST -> SM_SUM on an accepted non-last beat; any accepted tlast -> SM_FIRST.
- Sum word:
  - Non-last beats use tdata.
  - Last beat with tkeep=2'b10 uses {tdata[15:8],8'h00}, i.e. the odd-byte zero pad. Output data is passed unmasked.
  - Last beat with tkeep=2'b11 uses tdata.
  - tkeep 2'b00/2'b01 is illegal and is treated as 2'b11.
- Accumulator:
  - 17 bits; next = acc[15:0] + acc[16] + sum_word.
  - In SM_FIRST, acc is taken as 0 before the add.
- Word index:
  - Counts accepted beats per datagram and saturates at CSUM_WORD_IDX+1.
  - csum_zero latches (tdata==16'h0000) when index==CSUM_WORD_IDX.
- On an accepted tlast, fold = next[15:0] + next[16], folded a second time to 16 bits.
  - runt = index < CSUM_WORD_IDX, i.e. the datagram ended before or without the checksum word. A runt forces bit1=1 and bit0=0.
  - Otherwise bad = !csum_zero && fold != 16'hFFFF. A zero checksum field means "not computed" and always passes.
  - axis_o_tuser is registered with the beat.
- Counters update on input acceptance of tlast:
  - tuser==0 increments stat_ok_count; otherwise stat_bad_count increments.
  - Counters wrap modulo 2^COUNT_WIDTH.
- A single-beat datagram (tlast on word 0) is a runt unless CSUM_WORD_IDX==0.
- Reset mid-datagram: the partial datagram is discarded from the output (tvalid drops), no counter increments, and the remainder of the input is treated as a new datagram.

Test Plan:
- Stream 10 words: 0x1234, 0x0F00, seven 0x0000, then 0xDECB at index 9 with tlast -> 10 output beats, data identical, last-beat tuser=2'b00, stat_ok_count=1.
- Same stream with word1=0x0F01 -> last-beat tuser=2'b01, stat_bad_count=1.
  - Then, back-to-back, the same stream with word9=0x0000 -> tuser=2'b00 (checksum absent).
- Carry path: words 0xFFFF, 0x0002, seven 0x0000, 0xFFFD tlast -> tuser=2'b00.
- Odd byte: previous good 10-word stream with an 11th beat 0xAB55, tkeep=2'b10, tlast, and word9=0x33CB -> tuser=2'b00, output tdata=0xAB55.
  - Same datagram with tkeep=2'b11 -> tuser=2'b01.
- Runt: 5-word datagram with tlast on word 4 -> tuser=2'b10, stat_bad_count increments.
- Backpressure and reset:
  - Random axis_o_tready at 30% duty -> output sequence identical, no beat lost or duplicated.
  - Assert reset at word 6 -> axis_o_tvalid=0 within the same cycle, counters=0, next datagram verified correctly.
